// File: rtl/mc_ctrl_pkg.sv
// Shared codes for the multi-cycle MIPS control sequencer:
// opcodes, mux select encodings, ALU ops, states and bundles.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BR  = 3'd1;
  localparam logic [2:0] NPC_J26 = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [1:0] A3_RD = 2'd0;
  localparam logic [1:0] A3_RT = 2'd1;
  localparam logic [1:0] A3_RA = 2'd2;

  localparam logic [1:0] GWD_ALU = 2'd0;
  localparam logic [1:0] GWD_DM  = 2'd1;
  localparam logic [1:0] GWD_PC4 = 2'd2;

  localparam logic [1:0] SRCB_RD2 = 2'd0;
  localparam logic [1:0] SRCB_EXT = 2'd1;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_LUI = 4'd3;

  localparam logic [2:0] DM_WORD = 3'd0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  typedef struct packed {
    logic rtype_alu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } iclass_t;

  typedef struct packed {
    logic [2:0] npc_sel;
    logic [1:0] a3_sel;
    logic [1:0] gwd_sel;
    logic [1:0] srcb_sel;
    logic       ext_op;
    logic [3:0] alu_ctrl;
    logic [2:0] dm_sel;
  } sels_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/DM bundle: decode inputs,
// write enables, DM handshake and static mux selects.
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        dm_ack;
  logic        pc_we;
  logic        ir_we;
  logic        grf_we;
  logic        dm_req;
  logic        dm_we;
  logic [2:0]  npc_sel;
  logic [1:0]  a3_sel;
  logic [1:0]  gwd_sel;
  logic [1:0]  srcb_sel;
  logic        ext_op;
  logic [3:0]  alu_ctrl;
  logic [2:0]  dm_sel;
  logic [2:0]  state;
  logic        bus_err;

  modport master (
    input  instr, alu_zero, dm_ack,
    output pc_we, ir_we, grf_we,
    output dm_req, dm_we,
    output npc_sel, a3_sel, gwd_sel,
    output srcb_sel, ext_op, alu_ctrl,
    output dm_sel, state, bus_err
  );

  modport slave (
    output instr, alu_zero, dm_ack,
    input  pc_we, ir_we, grf_we,
    input  dm_req, dm_we,
    input  npc_sel, a3_sel, gwd_sel,
    input  srcb_sel, ext_op, alu_ctrl,
    input  dm_sel, state, bus_err
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: one-hot class plus
// the static mux selects, valid in every controller state.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  output iclass_t    cls,
  output sels_t      sel
);

  logic is_r;

  always_comb begin
    is_r = (op == OP_R);
    cls  = '0;
    unique case (1'b1)
      is_r && (funct == FN_ADDU ||
               funct == FN_SUBU): cls.rtype_alu = 1'b1;
      is_r && funct == FN_JR:     cls.jr  = 1'b1;
      op == OP_ORI:               cls.ori = 1'b1;
      op == OP_LUI:               cls.lui = 1'b1;
      op == OP_LW:                cls.lw  = 1'b1;
      op == OP_SW:                cls.sw  = 1'b1;
      op == OP_BEQ:               cls.beq = 1'b1;
      op == OP_J:                 cls.j   = 1'b1;
      op == OP_JAL:               cls.jal = 1'b1;
      default:                    cls.nop = 1'b1;
    endcase
  end

  always_comb begin
    sel          = '0;
    sel.npc_sel  = NPC_PC4;
    sel.a3_sel   = A3_RD;
    sel.gwd_sel  = GWD_ALU;
    sel.srcb_sel = SRCB_RD2;
    sel.ext_op   = 1'b0;
    sel.alu_ctrl = ALU_ADD;
    sel.dm_sel   = DM_WORD;
    unique case (1'b1)
      cls.rtype_alu: begin
        sel.alu_ctrl = (funct == FN_SUBU) ?
                       ALU_SUB : ALU_ADD;
      end
      cls.ori: begin
        sel.a3_sel   = A3_RT;
        sel.srcb_sel = SRCB_EXT;
        sel.alu_ctrl = ALU_OR;
      end
      cls.lui: begin
        sel.a3_sel   = A3_RT;
        sel.srcb_sel = SRCB_EXT;
        sel.alu_ctrl = ALU_LUI;
      end
      cls.lw: begin
        sel.a3_sel   = A3_RT;
        sel.gwd_sel  = GWD_DM;
        sel.srcb_sel = SRCB_EXT;
        sel.ext_op   = 1'b1;
      end
      cls.sw: begin
        sel.srcb_sel = SRCB_EXT;
        sel.ext_op   = 1'b1;
      end
      cls.beq: begin
        sel.npc_sel  = alu_zero ? NPC_BR : NPC_PC4;
        sel.ext_op   = 1'b1;
        sel.alu_ctrl = ALU_SUB;
      end
      cls.j: begin
        sel.npc_sel = NPC_J26;
      end
      cls.jal: begin
        sel.npc_sel = NPC_J26;
        sel.a3_sel  = A3_RA;
        sel.gwd_sel = GWD_PC4;
      end
      cls.jr: begin
        sel.npc_sel = NPC_JR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer: state register, DM wait counter,
// sticky bus error and per-phase write enables.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  iclass_t    cls;
  sels_t      sel;

  mc_decode u_dec (
    .op       (bus.instr[31:26]),
    .funct    (bus.instr[5:0]),
    .alu_zero (bus.alu_zero),
    .cls      (cls),
    .sel      (sel)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = cls.nop ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (cls.lw || cls.sw) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else if (cls.rtype_alu || cls.ori ||
                     cls.lui) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        // an ack on the last allowed cycle still wins
        if (bus.dm_ack) begin
          state_d = cls.sw ? S_FETCH : S_WB;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    err_d = err_q | (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  logic pc_we, ir_we, grf_we, dm_req, dm_we;

  always_comb begin
    pc_we  = 1'b0;
    ir_we  = 1'b0;
    grf_we = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    unique case (state_q)
      S_FETCH:  ir_we = 1'b1;
      S_DECODE: pc_we = cls.nop;
      S_EXEC: begin
        pc_we  = cls.beq | cls.j | cls.jr | cls.jal;
        grf_we = cls.jal;
      end
      S_MEM: begin
        dm_req = 1'b1;
        dm_we  = cls.sw;
        pc_we  = cls.sw & bus.dm_ack;
      end
      S_WB: begin
        pc_we  = 1'b1;
        grf_we = 1'b1;
      end
      default: ;
    endcase
    // reset kills every enable at once, including mid-MEM
    if (!reset) begin
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      grf_we = 1'b0;
      dm_req = 1'b0;
      dm_we  = 1'b0;
    end
  end

  assign bus.pc_we    = pc_we;
  assign bus.ir_we    = ir_we;
  assign bus.grf_we   = grf_we;
  assign bus.dm_req   = dm_req;
  assign bus.dm_we    = dm_we;
  assign bus.npc_sel  = sel.npc_sel;
  assign bus.a3_sel   = sel.a3_sel;
  assign bus.gwd_sel  = sel.gwd_sel;
  assign bus.srcb_sel = sel.srcb_sel;
  assign bus.ext_op   = sel.ext_op;
  assign bus.alu_ctrl = sel.alu_ctrl;
  assign bus.dm_sel   = sel.dm_sel;
  assign bus.state    = state_q;
  assign bus.bus_err  = err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expectations are queued
// by the stimulus and checked by a negedge monitor.
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();

  mc_ctrl #(.ACK_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2;
  localparam logic [2:0] M = 3'd3, W = 3'd4, X = 3'd5;
  // {pc_we, ir_we, grf_we, dm_req, dm_we}
  localparam logic [4:0] EN0  = 5'b00000;
  localparam logic [4:0] ENIR = 5'b01000;
  localparam logic [4:0] ENPC = 5'b10000;
  localparam logic [4:0] ENWB = 5'b10100;
  localparam logic [4:0] ENRD = 5'b00010;
  localparam logic [4:0] ENWR = 5'b00011;
  localparam logic [4:0] ENSA = 5'b10011;

  localparam logic [31:0] I_ADDU = 32'h0022_1821;
  localparam logic [31:0] I_SUBU = 32'h0022_1823;
  localparam logic [31:0] I_ORI  = 32'h3422_0055;
  localparam logic [31:0] I_LUI  = 32'h3C02_1234;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0008;
  localparam logic [31:0] I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_NOP  = 32'hFC00_0000;

  logic [22:0] expq[$];
  string       nmq[$];
  int          checks = 0;
  int          errors = 0;

  logic [2:0] c_npc;
  logic [1:0] c_a3, c_gwd, c_srcb;
  logic       c_ext;
  logic [3:0] c_alu;

  task automatic sel(input logic [2:0] npc,
                     input logic [1:0] a3,
                     input logic [1:0] gwd,
                     input logic [1:0] srcb,
                     input logic ext,
                     input logic [3:0] alu);
    c_npc = npc; c_a3 = a3; c_gwd = gwd;
    c_srcb = srcb; c_ext = ext; c_alu = alu;
  endtask

  task automatic step(input string nm,
                      input logic [31:0] i,
                      input logic z, input logic a,
                      input logic r,
                      input logic [2:0] st,
                      input logic [4:0] en,
                      input logic err);
    @(posedge clk);
    #1;
    bus.instr    = i;
    bus.alu_zero = z;
    bus.dm_ack   = a;
    reset        = r;
    expq.push_back({st, en, c_npc, c_a3, c_gwd,
                    c_srcb, c_ext, c_alu, err});
    nmq.push_back(nm);
  endtask

  always @(negedge clk) begin
    logic [22:0] e, act;
    string nm;
    if (expq.size() != 0) begin
      e  = expq.pop_front();
      nm = nmq.pop_front();
      act = {bus.state, bus.pc_we, bus.ir_we,
             bus.grf_we, bus.dm_req, bus.dm_we,
             bus.npc_sel, bus.a3_sel, bus.gwd_sel,
             bus.srcb_sel, bus.ext_op, bus.alu_ctrl,
             bus.bus_err};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", nm, act, e);
      end
    end
  end

  initial begin
    bus.instr    = 32'h0;
    bus.alu_zero = 1'b0;
    bus.dm_ack   = 1'b0;

    sel(0, 0, 0, 0, 0, 0);
    step("reset", 32'h0, 0, 0, 0, F, EN0, 0);

    step("addu_f", I_ADDU, 0, 0, 1, F, ENIR, 0);
    step("addu_d", I_ADDU, 0, 0, 1, D, EN0, 0);
    step("addu_e", I_ADDU, 0, 0, 1, E, EN0, 0);
    step("addu_wb", I_ADDU, 0, 0, 1, W, ENWB, 0);

    sel(0, 0, 0, 0, 0, 1);
    step("subu_f", I_SUBU, 0, 1, 1, F, ENIR, 0);
    step("subu_d", I_SUBU, 0, 1, 1, D, EN0, 0);
    step("subu_e", I_SUBU, 0, 1, 1, E, EN0, 0);
    step("subu_wb", I_SUBU, 0, 1, 1, W, ENWB, 0);

    sel(0, 1, 0, 1, 0, 2);
    step("ori_f", I_ORI, 0, 0, 1, F, ENIR, 0);
    step("ori_d", I_ORI, 0, 0, 1, D, EN0, 0);
    step("ori_e", I_ORI, 0, 0, 1, E, EN0, 0);
    step("ori_wb", I_ORI, 0, 0, 1, W, ENWB, 0);

    sel(0, 1, 0, 1, 0, 3);
    step("lui_f", I_LUI, 0, 0, 1, F, ENIR, 0);
    step("lui_d", I_LUI, 0, 0, 1, D, EN0, 0);
    step("lui_e", I_LUI, 0, 0, 1, E, EN0, 0);
    step("lui_wb", I_LUI, 0, 0, 1, W, ENWB, 0);

    sel(0, 1, 1, 1, 1, 0);
    step("lw_f", I_LW, 0, 0, 1, F, ENIR, 0);
    step("lw_d", I_LW, 0, 0, 1, D, EN0, 0);
    step("lw_e", I_LW, 0, 0, 1, E, EN0, 0);
    step("lw_m1", I_LW, 0, 0, 1, M, ENRD, 0);
    step("lw_m2", I_LW, 0, 0, 1, M, ENRD, 0);
    step("lw_m3", I_LW, 0, 1, 1, M, ENRD, 0);
    step("lw_wb", I_LW, 0, 0, 1, W, ENWB, 0);

    sel(0, 0, 0, 1, 1, 0);
    step("sw1_f", I_SW, 0, 0, 1, F, ENIR, 0);
    step("sw1_d", I_SW, 0, 0, 1, D, EN0, 0);
    step("sw1_e", I_SW, 0, 0, 1, E, EN0, 0);
    step("sw1_m1", I_SW, 0, 1, 1, M, ENSA, 0);

    step("sw15_f", I_SW, 0, 0, 1, F, ENIR, 0);
    step("sw15_d", I_SW, 0, 0, 1, D, EN0, 0);
    step("sw15_e", I_SW, 0, 0, 1, E, EN0, 0);
    for (int k = 0; k < 14; k++)
      step("sw15_wait", I_SW, 0, 0, 1, M, ENWR, 0);
    step("sw15_ack", I_SW, 0, 1, 1, M, ENSA, 0);

    sel(1, 0, 0, 0, 1, 1);
    step("beq1_f", I_BEQ, 1, 0, 1, F, ENIR, 0);
    step("beq1_d", I_BEQ, 1, 0, 1, D, EN0, 0);
    step("beq1_e", I_BEQ, 1, 0, 1, E, ENPC, 0);
    sel(0, 0, 0, 0, 1, 1);
    step("beq0_f", I_BEQ, 0, 0, 1, F, ENIR, 0);
    step("beq0_d", I_BEQ, 0, 0, 1, D, EN0, 0);
    step("beq0_e", I_BEQ, 0, 0, 1, E, ENPC, 0);

    sel(2, 0, 0, 0, 0, 0);
    step("j_f", I_J, 0, 0, 1, F, ENIR, 0);
    step("j_d", I_J, 0, 0, 1, D, EN0, 0);
    step("j_e", I_J, 0, 0, 1, E, ENPC, 0);

    sel(3, 0, 0, 0, 0, 0);
    step("jr_f", I_JR, 0, 0, 1, F, ENIR, 0);
    step("jr_d", I_JR, 0, 0, 1, D, EN0, 0);
    step("jr_e", I_JR, 0, 0, 1, E, ENPC, 0);

    sel(2, 2, 2, 0, 0, 0);
    step("jal_f", I_JAL, 0, 0, 1, F, ENIR, 0);
    step("jal_d", I_JAL, 0, 0, 1, D, EN0, 0);
    step("jal_e", I_JAL, 0, 0, 1, E, ENWB, 0);

    sel(0, 0, 0, 0, 0, 0);
    step("nop_f", I_NOP, 0, 0, 1, F, ENIR, 0);
    step("nop_d", I_NOP, 0, 0, 1, D, ENPC, 0);

    // reset pulled low in the second MEM cycle of a store
    sel(0, 0, 0, 1, 1, 0);
    step("swr_f", I_SW, 0, 0, 1, F, ENIR, 0);
    step("swr_d", I_SW, 0, 0, 1, D, EN0, 0);
    step("swr_e", I_SW, 0, 0, 1, E, EN0, 0);
    step("swr_m1", I_SW, 0, 0, 1, M, ENWR, 0);
    step("swr_rst", I_SW, 0, 0, 0, F, EN0, 0);
    step("swr_hold", I_SW, 0, 1, 0, F, EN0, 0);

    step("swto_f", I_SW, 0, 0, 1, F, ENIR, 0);
    step("swto_d", I_SW, 0, 0, 1, D, EN0, 0);
    step("swto_e", I_SW, 0, 0, 1, E, EN0, 0);
    for (int k = 0; k < 15; k++)
      step("swto_wait", I_SW, 0, 0, 1, M, ENWR, 0);
    for (int k = 0; k < 22; k++)
      step("err_hold", I_SW, 0, k[0], 1, X, EN0, 1);

    step("err_rst", I_SW, 0, 0, 0, F, EN0, 0);
    step("post_f", I_SW, 0, 0, 1, F, ENIR, 0);

    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0",
               expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
